// File: rtl/empty_ptr_storage.sv
// empty_ptr_storage
//   Free-list of data-table addresses. After reset the block writes every
//   table address into its FIFO RAM (INIT_S). It then serves them oldest-first
//   to the insert engine through a show-ahead valid/ack port (RUN_S).
//   The delete engine returns freed addresses through add_empty_ptr_*.
//
//   Optional feature: define EMPTY_PTR_DOUBLE_FREE_CHECK_EN to add a per-address
//   is_free bitmap. A push of an address that is already free is then dropped
//   and flagged on double_free_o. Without the macro, double_free_o is tied to 0.
//
// Ports
//   clk_i                 in   clock
//   rst_n_i               in   synchronous active-low reset
//   add_empty_ptr_i       in   [A_WIDTH]   address being freed
//   add_empty_ptr_en_i    in   strobe: push add_empty_ptr_i
//   next_empty_ptr_o      out  [A_WIDTH]   oldest free address (show-ahead)
//   next_empty_ptr_val_o  out  next_empty_ptr_o is valid
//   next_empty_ptr_ack_i  in   consumer takes next_empty_ptr_o this cycle
//   init_done_o           out  initial fill complete
//   empty_o               out  no free address stored
//   free_cnt_o            out  [A_WIDTH+1] stored free addresses, 0..DEPTH
//   add_overflow_o        out  sticky: a push was dropped (full or INIT_S)
//   ack_underflow_o       out  sticky: ack seen while valid was low
//   double_free_o         out  sticky: push of an already-free address dropped
module empty_ptr_storage #(
  parameter int A_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_ack_i,
  output logic               init_done_o,
  output logic               empty_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               add_overflow_o,
  output logic               ack_underflow_o,
  output logic               double_free_o
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH+1)'(DEPTH);

  localparam logic [0:0] INIT_S = 1'b0;
  localparam logic [0:0] RUN_S  = 1'b1;

  logic [0:0]         state_reg;
  logic [A_WIDTH:0]   init_cnt_reg;
  logic [A_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [A_WIDTH-1:0] wr_ptr_reg;
  logic [A_WIDTH:0]   free_cnt_reg, free_cnt_next;
  logic [A_WIDTH-1:0] rd_data_reg;
  logic               val_reg, init_done_reg, empty_reg;
  logic               overflow_reg, underflow_reg;

  logic [A_WIDTH-1:0] mem [DEPTH];

  logic               run, last_init, pop_acc, push_acc, room, dfree_hit;
  logic               we;
  logic [A_WIDTH-1:0] waddr, wdata;

  always_comb begin
    run         = (state_reg == RUN_S);
    last_init   = !run && (init_cnt_reg == DEPTH_C - 1'b1);
    pop_acc     = run && next_empty_ptr_ack_i && val_reg;
    // Fullness is judged after this cycle's pop, so a push alongside a pop
    // into a full FIFO still fits.
    room        = (free_cnt_reg != DEPTH_C) || pop_acc;
    push_acc    = run && add_empty_ptr_en_i && room && !dfree_hit;
    rd_ptr_next = rd_ptr_reg + A_WIDTH'(pop_acc);
    free_cnt_next = free_cnt_reg + (A_WIDTH+1)'(push_acc) - (A_WIDTH+1)'(pop_acc);
    // Single write port shared by the init fill and run-time pushes.
    we    = !run || push_acc;
    waddr = run ? wr_ptr_reg      : init_cnt_reg[A_WIDTH-1:0];
    wdata = run ? add_empty_ptr_i : init_cnt_reg[A_WIDTH-1:0];
  end

  // RAM: no reset on the array; the read register always tracks the head
  // (post-pop) and forwards the write data when addresses collide.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_data_reg <= '0;
    end else if (we && (waddr == rd_ptr_next)) begin
      rd_data_reg <= wdata;
    end else begin
      rd_data_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= INIT_S;
      init_cnt_reg  <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      free_cnt_reg  <= '0;
      val_reg       <= 1'b0;
      init_done_reg <= 1'b0;
      empty_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (!run) begin
        init_cnt_reg <= init_cnt_reg + 1'b1;
        val_reg      <= 1'b0;
        if (last_init) begin
          state_reg     <= RUN_S;
          wr_ptr_reg    <= '0;
          rd_ptr_reg    <= '0;
          free_cnt_reg  <= DEPTH_C;
          empty_reg     <= 1'b0;
          init_done_reg <= 1'b1;
        end
      end else begin
        rd_ptr_reg   <= rd_ptr_next;
        if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        free_cnt_reg <= free_cnt_next;
        empty_reg    <= (free_cnt_next == '0);
        // Valid drops for one cycle after a pop while the RAM re-reads the
        // new head; it is qualified by the registered count, so a push into
        // an empty FIFO shows up two cycles later.
        val_reg      <= (free_cnt_reg != '0) && !pop_acc;
      end
      if (add_empty_ptr_en_i && !push_acc && !dfree_hit) overflow_reg <= 1'b1;
      if (next_empty_ptr_ack_i && !val_reg) underflow_reg <= 1'b1;
    end
  end

`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] is_free_reg;
  logic             dfree_reg;

  assign dfree_hit = run && add_empty_ptr_en_i && is_free_reg[add_empty_ptr_i];

  // A push and a pop of the same address in one cycle cannot both be
  // accepted (the head is free, so that push is a double free).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_is_free
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        is_free_reg[gi] <= 1'b0;
      end else if (!run && (init_cnt_reg[A_WIDTH-1:0] == A_WIDTH'(gi))) begin
        is_free_reg[gi] <= 1'b1;
      end else if (push_acc && (add_empty_ptr_i == A_WIDTH'(gi))) begin
        is_free_reg[gi] <= 1'b1;
      end else if (pop_acc && (rd_data_reg == A_WIDTH'(gi))) begin
        is_free_reg[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) dfree_reg <= 1'b0;
    else if (dfree_hit) dfree_reg <= 1'b1;
  end

  assign double_free_o = dfree_reg;
`else
  assign dfree_hit     = 1'b0;
  assign double_free_o = 1'b0;
`endif

  assign next_empty_ptr_o     = rd_data_reg;
  assign next_empty_ptr_val_o = val_reg;
  assign init_done_o          = init_done_reg;
  assign empty_o              = empty_reg;
  assign free_cnt_o           = free_cnt_reg;
  assign add_overflow_o       = overflow_reg;
  assign ack_underflow_o      = underflow_reg;

endmodule
